// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit/receive stages.
//   tx_state_t          : transmitter state encoding (also usable for debug)
//   UART_DATA_BITS      : data bits per frame (8n1 framing)
//   UART_CHECKSUM_WIDTH : width of the optional running byte checksum
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_CHECKSUM_WIDTH = 32;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter shared by the UART transmitter and receiver.
// The counter runs 0..cycles_per_bit-1 and wraps; the wrap cycle is the last
// cycle of the current serial bit.
//
// Parameters:
//   cycles_per_bit : clocks per serial bit (>= 2)
// Ports:
//   clock           in  : clock, all state updates on posedge
//   tick_reset      in  : synchronous active-high reset, counter -> 0
//   tick_restart    in  : hold the counter at 0 (next cycle is bit cycle 0)
//   get_bit_end_ret out : high during the last cycle of a bit period
// ---------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int cycles_per_bit = 4
) (
  input  logic clock,
  input  logic tick_reset,
  input  logic tick_restart,
  output logic get_bit_end_ret
);

  localparam int W = (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;
  localparam logic [W-1:0] LAST = W'(cycles_per_bit - 1);

  logic [W-1:0] bit_delay;

  always_ff @(posedge clock) begin
    if (tick_reset || tick_restart) begin
      bit_delay <= '0;
    end else if (bit_delay == LAST) begin
      bit_delay <= '0;
    end else begin
      bit_delay <= bit_delay + W'(1);
    end
  end

  assign get_bit_end_ret = (bit_delay == LAST);

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// 8n1 serial transmitter with a one-byte holding register. A producer can
// queue the next byte while the current frame shifts out; back-to-back frames
// follow each other with no idle cycle between the stop and start bits.
//
// Handshake: a byte is transferred on a posedge where tick_req is high and
// get_cts_ret is high (and tick_reset is low). tick_data is sampled only on
// that edge. While get_cts_ret is low, tick_req is ignored and the producer
// must keep offering the byte.
//
// Parameters:
//   cycles_per_bit : clocks per serial bit (>= 2)
//   stop_bits      : 1 or 2
// Ports:
//   clock            in      : clock
//   tick_reset       in      : synchronous active-high reset (aborts frame,
//                              discards any held byte)
//   tick_req         in      : producer offers tick_data
//   tick_data        in  [8] : byte to transmit (LSB first)
//   get_serial_ret   out     : serial line, idles high
//   get_cts_ret      out     : clear-to-send (holding register empty)
//   get_idle_ret     out     : shifter idle and holding register empty
//   get_checksum_ret out [32]: only with UART_TX_CHECKSUM_EN; running sum of
//                              every byte whose frame completed, mod 2^32
//
// Optional build macro: UART_TX_CHECKSUM_EN
// ---------------------------------------------------------------------------
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int cycles_per_bit = 4,
  parameter int stop_bits      = 1
) (
  input  logic       clock,
  input  logic       tick_reset,
  input  logic       tick_req,
  input  logic [7:0] tick_data,
  output logic       get_serial_ret,
  output logic       get_cts_ret,
  output logic       get_idle_ret
`ifdef UART_TX_CHECKSUM_EN
  ,
  output logic [UART_CHECKSUM_WIDTH-1:0] get_checksum_ret
`endif
);

  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(stop_bits - 1);

  tx_state_t  tx_state;
  logic [2:0] bit_count;
  logic [7:0] shift;
  logic [7:0] hold_data;
  logic       hold_full;

  logic bit_end;
  logic frame_end;
  logic accept;
  logic direct_load;

  // The timer is parked at 0 while idle, so the start bit of a frame loaded
  // from idle always gets a full bit period. Between back-to-back frames the
  // counter simply wraps, which gives the same result.
  uart_bit_timer #(
    .cycles_per_bit(cycles_per_bit)
  ) u_bit_timer (
    .clock          (clock),
    .tick_reset     (tick_reset),
    .tick_restart   (tx_state == TX_IDLE),
    .get_bit_end_ret(bit_end)
  );

  assign frame_end = (tx_state == TX_STOP) && bit_end && (bit_count == LAST_STOP);
  assign accept    = tick_req && !hold_full;
  // A new byte bypasses the holding register when the shifter is free on
  // this edge: either idle, or finishing a frame with nothing queued.
  assign direct_load = accept && ((tx_state == TX_IDLE) || (frame_end && !hold_full));

  always_ff @(posedge clock) begin
    if (tick_reset) begin
      tx_state  <= TX_IDLE;
      bit_count <= '0;
      shift     <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (direct_load) begin
            shift    <= tick_data;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            tx_state  <= TX_DATA;
            bit_count <= '0;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_count == LAST_DATA) begin
              tx_state  <= TX_STOP;
              bit_count <= '0;
            end else begin
              bit_count <= bit_count + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            if (bit_count != LAST_STOP) begin
              bit_count <= bit_count + 3'd1;
            end else begin
              bit_count <= '0;
              if (hold_full) begin
                // Queued byte goes straight out: no idle cycle on the line.
                shift     <= hold_data;
                hold_full <= 1'b0;
                tx_state  <= TX_START;
              end else if (direct_load) begin
                shift    <= tick_data;
                tx_state <= TX_START;
              end else begin
                tx_state <= TX_IDLE;
              end
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase

      // accept implies hold_full was 0, so this never collides with the
      // clear at frame end above.
      if (accept && !direct_load) begin
        hold_data <= tick_data;
        hold_full <= 1'b1;
      end
    end
  end

  always_comb begin
    get_serial_ret = 1'b1;
    unique case (tx_state)
      TX_IDLE:  get_serial_ret = 1'b1;
      TX_START: get_serial_ret = 1'b0;
      TX_DATA:  get_serial_ret = shift[0];
      TX_STOP:  get_serial_ret = 1'b1;
      default:  get_serial_ret = 1'b1;
    endcase
  end

  assign get_cts_ret  = !hold_full;
  assign get_idle_ret = (tx_state == TX_IDLE) && !hold_full;

`ifdef UART_TX_CHECKSUM_EN
  // The shifter is consumed as bits go out, so keep a copy of the byte in
  // flight and add it when its last stop cycle completes.
  logic [7:0]                     frame_byte;
  logic [UART_CHECKSUM_WIDTH-1:0] checksum;

  always_ff @(posedge clock) begin
    if (tick_reset) begin
      frame_byte <= '0;
      checksum   <= '0;
    end else begin
      if (direct_load) begin
        frame_byte <= tick_data;
      end else if (frame_end && hold_full) begin
        frame_byte <= hold_data;
      end
      if (frame_end) begin
        checksum <= checksum + UART_CHECKSUM_WIDTH'(frame_byte);
      end
    end
  end

  assign get_checksum_ret = checksum;
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
// Bench for uart_tx_buffered. Instance A (cycles_per_bit=4, stop_bits=1) is
// compared every cycle against a frame-level reference model, and its line is
// decoded by a receiver model whose bytes are scoreboarded against the bytes
// the model says completed. Instance B (stop_bits=2) covers the longer frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

  localparam int CPB     = 4;
  localparam int SB      = 1;
  localparam int FRAME   = (10 + SB - 1) * CPB;
  localparam int FRAME_B = (10 + 2 - 1) * CPB;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       ser_a, cts_a, idle_a;
  logic       ser_b, cts_b, idle_b;
`ifdef UART_TX_CHECKSUM_EN
  logic [31:0] csum_a, csum_b;
`endif

  uart_tx_buffered #(.cycles_per_bit(CPB), .stop_bits(SB)) dut_a (
    .clock(clk), .tick_reset(rst), .tick_req(req_a), .tick_data(data_a),
    .get_serial_ret(ser_a), .get_cts_ret(cts_a), .get_idle_ret(idle_a)
`ifdef UART_TX_CHECKSUM_EN
    , .get_checksum_ret(csum_a)
`endif
  );

  uart_tx_buffered #(.cycles_per_bit(CPB), .stop_bits(2)) dut_b (
    .clock(clk), .tick_reset(rst), .tick_req(req_b), .tick_data(data_b),
    .get_serial_ret(ser_b), .get_cts_ret(cts_b), .get_idle_ret(idle_b)
`ifdef UART_TX_CHECKSUM_EN
    , .get_checksum_ret(csum_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a frame is FRAME cycles; m_e is the cycle index of the
  // current sample inside the frame
  bit          m_active, m_held;
  int          m_e;
  logic [7:0]  m_byte, m_hbyte;
  logic [31:0] m_csum;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];

  function automatic logic m_serial();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_e / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit acc, used;
    if (rst) begin
      m_active = 0; m_held = 0; m_e = 0; m_csum = 0;
      return;
    end
    acc  = req_a && !m_held;
    used = 0;
    if (m_active) begin
      if (m_e == FRAME - 1) begin
        exp_q.push_back(m_byte);
        m_csum = m_csum + {24'd0, m_byte};
        m_e    = 0;
        if (m_held) begin
          m_byte = m_hbyte; m_held = 0;
        end else if (acc) begin
          m_byte = data_a; used = 1;
        end else begin
          m_active = 0;
        end
      end else begin
        m_e++;
      end
    end else if (acc) begin
      m_active = 1; m_byte = data_a; m_e = 0; used = 1;
    end
    if (acc && !used) begin
      m_held = 1; m_hbyte = data_a;
    end
  endtask

  // receiver model on line A
  bit         rx_active, rx_pend;
  int         rx_s;
  logic [7:0] rx_byte, rx_pbyte;

  task automatic rx_sample();
    if (!rx_active) begin
      if (ser_a === 1'b0) begin
        rx_active = 1; rx_s = 1;
      end
    end else begin
      rx_s++;
      for (int i = 0; i < 8; i++)
        if (rx_s == CPB * (i + 1) + CPB / 2 + 1) rx_byte[i] = ser_a;
      if (rx_s == FRAME) begin
        rx_pend = 1; rx_pbyte = rx_byte; rx_active = 0;
      end
    end
  endtask

  // one clock: edge, model update, sample at negedge, compare, scoreboard
  task automatic step();
    @(posedge clk);
    model_edge();
    if (rst) begin
      rx_active = 0; rx_pend = 0;
    end else if (rx_pend) begin
      got_q.push_back(rx_pbyte); rx_pend = 0;
    end
    @(negedge clk);
    check("serial", {31'd0, ser_a}, {31'd0, m_serial()});
    check("cts", {31'd0, cts_a}, {31'd0, !m_held});
    check("idle", {31'd0, idle_a}, {31'd0, (!m_active && !m_held)});
`ifdef UART_TX_CHECKSUM_EN
    check("checksum", csum_a, m_csum);
`endif
    rx_sample();
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("rx_byte", {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
  endtask

  // driver: offer a byte until the handshake edge passes
  task automatic send(input logic [7:0] b);
    logic pre;
    req_a = 1'b1; data_a = b;
    for (int k = 0; k < 400; k++) begin
      pre = cts_a;
      step();
      if (pre === 1'b1) break;
    end
    req_a = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && idle_a !== 1'b1; k++) step();
    check("wait_idle", {31'd0, idle_a}, 32'd1);
  endtask

  typedef struct {
    logic       req;
    logic [7:0] data;
    int         n;
    logic       ser;
    logic       cts;
    logic       idle;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int   busy, accepted, lows;
    logic pre;

    // single 0x55 frame: row applies req/data on its first cycle, then runs
    // n cycles in total and checks the sample reached
    tbl[0] = '{1'b1, 8'h55, 1,  1'b0, 1'b1, 1'b0};  // sample 1: start
    tbl[1] = '{1'b0, 8'h00, 3,  1'b0, 1'b1, 1'b0};  // sample 4: start
    tbl[2] = '{1'b0, 8'h00, 1,  1'b1, 1'b1, 1'b0};  // sample 5: bit0=1
    tbl[3] = '{1'b0, 8'h00, 4,  1'b0, 1'b1, 1'b0};  // sample 9: bit1=0
    tbl[4] = '{1'b0, 8'h00, 4,  1'b1, 1'b1, 1'b0};  // sample 13: bit2=1
    tbl[5] = '{1'b0, 8'h00, 23, 1'b0, 1'b1, 1'b0};  // sample 36: bit7=0
    tbl[6] = '{1'b0, 8'h00, 1,  1'b1, 1'b1, 1'b0};  // sample 37: stop
    tbl[7] = '{1'b0, 8'h00, 3,  1'b1, 1'b1, 1'b0};  // sample 40: stop
    tbl[8] = '{1'b0, 8'h00, 1,  1'b1, 1'b1, 1'b1};  // sample 41: idle

    rst = 1'b1; req_a = 0; data_a = 0; req_b = 0; data_b = 0;
    m_active = 0; m_held = 0; m_e = 0; m_csum = 0;
    rx_active = 0; rx_pend = 0; rx_s = 0; rx_byte = 0; rx_pbyte = 0;
    step();
    step();
    check("reset_serial", {31'd0, ser_a}, 32'd1);
    check("reset_cts", {31'd0, cts_a}, 32'd1);
    check("reset_idle", {31'd0, idle_a}, 32'd1);
    rst = 1'b0;
    step();

    // stop_bits=2: 0xFF then 0x00 queued; 4 low, 40 high, next start at 45
    req_b = 1'b1; data_b = 8'hFF;
    step();
    check("b_start_s1", {31'd0, ser_b}, 32'd0);
    data_b = 8'h00;
    step();
    req_b = 1'b0;
    check("b_hold_cts", {31'd0, cts_b}, 32'd0);
    for (int s = 3; s <= FRAME_B + 1; s++) begin
      step();
      check("b_line", {31'd0, ser_b}, (s <= CPB || s == FRAME_B + 1) ? 32'd0 : 32'd1);
    end
    repeat (FRAME_B + 10) step();
    check("b_done_idle", {31'd0, idle_b}, 32'd1);

    // table: 0x55 waveform
    for (int i = 0; i < 9; i++) begin
      req_a = tbl[i].req; data_a = tbl[i].data;
      step();
      req_a = 1'b0;
      repeat (tbl[i].n - 1) step();
      check("t55_serial", {31'd0, ser_a}, {31'd0, tbl[i].ser});
      check("t55_cts", {31'd0, cts_a}, {31'd0, tbl[i].cts});
      check("t55_idle", {31'd0, idle_a}, {31'd0, tbl[i].idle});
    end

    // back-to-back 0x48, 0x69: 80 contiguous busy cycles
    req_a = 1'b1; data_a = 8'h48;
    step();
    data_a = 8'h69;
    step();
    req_a = 1'b0;
    check("b2b_cts_low", {31'd0, cts_a}, 32'd0);
    busy = 0;
    for (int k = 0; k < 200 && idle_a !== 1'b1; k++) begin
      step(); busy++;
    end
    check("b2b_busy_cycles", busy + 1, 2 * FRAME);

    // backpressure: 0xAA offered while hold is full, taken exactly once
    send(8'h11);
    send(8'h22);
    req_a = 1'b1; data_a = 8'hAA; accepted = 0;
    for (int k = 0; k < 60; k++) begin
      pre = cts_a;
      step();
      if (req_a && pre === 1'b1) begin
        accepted++; req_a = 1'b0;
      end
    end
    req_a = 1'b0;
    check("bp_accept_count", accepted, 1);
    wait_idle();

    // reset during DATA bit 3 with a held byte
    req_a = 1'b1; data_a = 8'h33;
    step();
    data_a = 8'h44;
    step();
    req_a = 1'b0;
    repeat (16) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_serial", {31'd0, ser_a}, 32'd1);
    check("rst_mid_cts", {31'd0, cts_a}, 32'd1);
    check("rst_mid_idle", {31'd0, idle_a}, 32'd1);
    lows = 0;
    repeat (100) begin
      step();
      if (ser_a !== 1'b1) lows++;
    end
    check("rst_mid_no_tx", lows, 0);

`ifdef UART_TX_CHECKSUM_EN
    rst = 1'b1; step(); rst = 1'b0;
    send(8'h48); send(8'h65); send(8'h6C); send(8'h6C); send(8'h6F);
    wait_idle();
    check("hello_checksum", csum_a, 32'h1F4);
`endif

    // randomized traffic with occasional resets
    repeat (3000) begin
      req_a  = ($urandom_range(0, 2) == 0);
      data_a = 8'($urandom);
      rst    = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0; req_a = 1'b0;
    repeat (2 * FRAME + 10) step();

    check("exp_q_left", exp_q.size(), 0);
    check("got_q_left", got_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
8n1 serial transmitter that drives the line into the UART receiver stage directly downstream.
- Accepts bytes over a valid/ready-style handshake.
- Has a one-byte holding register so a producer can queue the next byte while the current frame shifts out.
- Back-to-back frames leave no idle gap on the line.
- Bit timing matches the receiver: cycles_per_bit clocks per bit.

Parameters:
- cycles_per_bit, 4, clocks per serial bit; must be >= 2.
- stop_bits, 1, number of stop bits; legal values 1 or 2.

Ports:
- clock  input  1  global clock, all state updates on posedge
- tick_reset  input  1  synchronous, active-high reset
- tick_req  input  1  producer offers tick_data this cycle
- tick_data  input  8  byte to transmit
- get_serial_ret  output  1  serial line; idles high
- get_cts_ret  output  1  clear-to-send; tick_req is accepted only when high
- get_idle_ret  output  1  high when the shifter is idle and the holding register is empty

Behaviour:
- Interface: one clock (clock); reset tick_reset is synchronous and active-high.
- State machine tx_state: IDLE, START, DATA, STOP.
- Registers:
  - bit_delay: width $clog2(cycles_per_bit), counts 0..cycles_per_bit-1.
  - bit_count: 0..7 in DATA, 0..stop_bits-1 in STOP.
  - shift: 8 bits.
  - hold_data: 8 bits.
  - hold_full: 1 bit.
- get_serial_ret is combinational from state:
  - IDLE: 1
  - START: 0
  - DATA: shift[0]
  - STOP: 1
- get_cts_ret = !hold_full. get_idle_ret = (state==IDLE) && !hold_full.
- Reset (takes priority over everything):
  - state=IDLE, bit_delay=0, bit_count=0, shift=0, hold_full=0.
  - Outputs after the reset edge: serial=1, cts=1, idle=1.
  - Reset mid-frame aborts the frame: line returns high the cycle after the reset edge; any held byte is discarded.
- Bit timing: each of START, every DATA bit and every STOP bit lasts exactly cycles_per_bit cycles.
  - bit_delay increments each cycle and wraps to 0 when it reaches cycles_per_bit-1; that wrap cycle is the bit's "last cycle".
- Transitions at the end of a bit's last cycle:
  - START -> DATA, bit_count=0.
  - DATA: shift >>= 1 and bit_count++; after bit 7, go to STOP with bit_count=0.
  - STOP: if bit_count < stop_bits-1, increment. Otherwise frame ends: load the next byte (see below) into START, or go to IDLE.
- Frame length: (10 + stop_bits - 1) * cycles_per_bit cycles. Data is sent LSB first.
- Acceptance: a handshake occurs at a posedge where tick_req && get_cts_ret && !tick_reset. Destination:
  - If state==IDLE, or the frame ends on this same edge with hold_full==0: load shift directly and enter START, bit_delay=0. The serial line goes low the cycle after the handshake edge.
  - Otherwise: write hold_data and set hold_full=1.
- Frame end with hold_full==1: shift=hold_data, hold_full=0, enter START with no idle cycle between stop bit and start bit. A tick_req on that edge is not accepted, because cts was low.
- tick_req while cts is low: ignored; no state change, data dropped by the protocol (the producer must hold it).
- tick_data is sampled only on the handshake edge.

Optional Feature:
UART_TX_CHECKSUM_EN
- Defined: adds a 32-bit register checksum and an output get_checksum_ret (32).
  - checksum += zero-extended byte when that byte's frame ends (last stop cycle); wraps modulo 2^32.
  - Reset clears it to 0.
  - Must equal the receiver's checksum after identical traffic.
- Undefined: no checksum register or port; behaviour otherwise identical.

Decomposition:
- Shared package uart_pkg:
  - typedef tx_state_t enum (TX_IDLE, TX_START, TX_DATA, TX_STOP)
  - localparam UART_DATA_BITS=8
  - localparam UART_CHECKSUM_WIDTH=32
- One natural sub-module: uart_bit_timer.
  - Parameterised by cycles_per_bit.
  - Ports: clock, tick_reset, tick_restart; output get_bit_end_ret.
  - Reusable by the receiver.
- The holding register and FSM stay in uart_tx_buffered.

Test Plan:
- Single byte, cycles_per_bit=4, stop_bits=1. Send 0x55 from idle. Line must read: 4 cycles 0, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then 4 cycles 1. Total 40 cycles; idle=1 from cycle 41.
- Back-to-back: req 0x48 then 0x69 on consecutive cycles. Second is accepted into hold (cts drops to 0), cts returns to 1 at the first frame's end, and 80 contiguous frame cycles occur with no idle gap.
- Backpressure: hold full and tick_req=1 with 0xAA for 20 cycles. 0xAA is accepted only on the first cycle cts=1, and is transmitted exactly once.
- Reset mid-frame: assert tick_reset during DATA bit 3 with a held byte. Next cycle serial=1, cts=1, idle=1; the held byte is never transmitted.
- stop_bits=2: send 0xFF. Frame is 44 cycles: 4 cycles low, then 40 cycles high. The next byte's start bit begins at cycle 45.
- Loopback (UART_TX_CHECKSUM_EN): drive into the receiver, bytes "Hello" (0x48,0x65,0x6C,0x6C,0x6F). Receiver data matches each byte; both checksums equal 0x1F4.
